// File: rtl/conv_feeder.sv
// Frame-buffer streamer: holds one IMG_N x IMG_N frame and replays it row-major, one pixel per cycle.
// Define CONV_FEEDER_ROW_PAD_EN to insert K-1 zero beats after every row.
module conv_feeder #(
    parameter int DATA_W = 16,
    parameter int IMG_N  = 6,
    parameter int K      = 3,
    localparam int AW    = $clog2(IMG_N * IMG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              hold,
    output logic [DATA_W-1:0] pixel_out,
    output logic              pix_en,
    output logic              row_start,
    output logic              frame_done,
    output logic              busy
);

    localparam int NPIX = IMG_N * IMG_N;
    localparam int CW   = (IMG_N > 1) ? $clog2(IMG_N) : 1;

    if (K < 2) begin : g_k_check
        $error("conv_feeder: K must be at least 2");
    end

`ifdef CONV_FEEDER_ROW_PAD_EN
    localparam int PW = (K > 2) ? $clog2(K - 1) : 1;
    typedef enum logic [1:0] {IDLE, STREAM, PAD, DONE} state_t;
    logic [PW-1:0] pad_cnt;
`else
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
`endif

    state_t            state;
    logic [CW-1:0]     row;
    logic [CW-1:0]     col;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] mem [NPIX];

    logic last_col;
    logic last_row;

    assign rd_addr  = AW'(row) * AW'(IMG_N) + AW'(col);
    assign last_col = (col == CW'(IMG_N - 1));
    assign last_row = (row == CW'(IMG_N - 1));

    // Busy also covers the cycle after DONE, so writes are gated on both.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && !busy && (32'(wr_addr) < NPIX))
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            pixel_out  <= '0;
            pix_en     <= 1'b0;
            row_start  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
`ifdef CONV_FEEDER_ROW_PAD_EN
            pad_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pix_en     <= 1'b0;
                    row_start  <= 1'b0;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    if (start && !busy) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                    end
                end

                STREAM: begin
                    if (hold) begin
                        pix_en    <= 1'b0;
                        row_start <= 1'b0;
                    end else begin
                        pixel_out <= mem[rd_addr];
                        pix_en    <= 1'b1;
                        row_start <= (col == '0);
                        if (last_col) begin
                            col <= '0;
`ifdef CONV_FEEDER_ROW_PAD_EN
                            state   <= PAD;
                            pad_cnt <= '0;
`else
                            if (last_row) begin
                                row   <= '0;
                                state <= DONE;
                            end else begin
                                row <= row + 1'b1;
                            end
`endif
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end

`ifdef CONV_FEEDER_ROW_PAD_EN
                PAD: begin
                    row_start <= 1'b0;
                    if (hold) begin
                        pix_en <= 1'b0;
                    end else begin
                        pixel_out <= '0;
                        pix_en    <= 1'b1;
                        pad_cnt   <= pad_cnt + 1'b1;
                        if (pad_cnt == PW'(K - 2)) begin
                            pad_cnt <= '0;
                            if (last_row) begin
                                row   <= '0;
                                state <= DONE;
                            end else begin
                                row   <= row + 1'b1;
                                state <= STREAM;
                            end
                        end
                    end
                end
`endif

                DONE: begin
                    pix_en     <= 1'b0;
                    row_start  <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_feeder.sv
// Self-checking bench for conv_feeder: table of frame runs with a pixel scoreboard, plus reset/abort sequences.
// Expectations follow CONV_FEEDER_ROW_PAD_EN when it is defined.
module tb_conv_feeder;

    localparam int DATA_W = 16;
    localparam int IMG_N  = 6;
    localparam int K      = 3;
    localparam int AW     = $clog2(IMG_N * IMG_N);
`ifdef CONV_FEEDER_ROW_PAD_EN
    localparam int PADN   = K - 1;
`else
    localparam int PADN   = 0;
`endif
    localparam int NB     = IMG_N * (IMG_N + PADN);

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              hold;
    logic [DATA_W-1:0] pixel_out;
    logic              pix_en;
    logic              row_start;
    logic              frame_done;
    logic              busy;

    conv_feeder #(.DATA_W(DATA_W), .IMG_N(IMG_N), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .hold       (hold),
        .pixel_out  (pixel_out),
        .pix_en     (pix_en),
        .row_start  (row_start),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] val;
        logic              rs;
    } beat_t;

    typedef struct {
        int hold_at;
        int hold_len;
        int exp_cycles;
        bit wr_on_start;
        bit busy_poke;
    } vec_t;

    beat_t exp_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push_frame();
        for (int r = 0; r < IMG_N; r++) begin
            for (int c = 0; c < IMG_N; c++) begin
                beat_t b;
                b.val = DATA_W'(r * IMG_N + c + 1);
                b.rs  = (c == 0);
                exp_q.push_back(b);
            end
            for (int p = 0; p < PADN; p++) begin
                beat_t b;
                b.val = '0;
                b.rs  = 1'b0;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic check_beat();
        beat_t b;
        if (exp_q.size() == 0) begin
            chk("extra_beat", 1, 0);
        end else begin
            b = exp_q.pop_front();
            chk("pixel_out", pixel_out, b.val);
            chk("row_start", row_start, b.rs);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int          cyc;
        int          hcnt;
        int          beats;
        bit          held;
        bit          got_done;
        logic [DATA_W-1:0] last;
        push_frame();
        @(negedge clk);
        start = 1'b1;
        if (v.wr_on_start) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = 16'd1;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        cyc = 1; hcnt = 0; beats = 0; held = 0; got_done = 0; last = '0;
        chk("busy_after_start", busy, 1);
        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; wr_en = 1'b0;
            if (hcnt > 0) begin
                chk("hold_pix_en", pix_en, 0);
                chk("hold_pixel", pixel_out, last);
                hcnt--;
                if (hcnt == 0) hold = 1'b0;
            end else if (pix_en) begin
                check_beat();
                last = pixel_out;
                beats++;
                if (v.hold_len > 0 && !held && pixel_out == DATA_W'(v.hold_at)) begin
                    hold = 1'b1; hcnt = v.hold_len; held = 1;
                end
                if (v.busy_poke && beats == 5) begin
                    wr_en = 1'b1; wr_addr = '0; wr_data = 16'hFFFF; start = 1'b1;
                end
            end else if (frame_done) begin
                got_done = 1;
                chk("queue_drained", exp_q.size(), 0);
                chk("frame_cycles", cyc, v.exp_cycles);
                chk("beat_count", beats, NB);
                chk("busy_at_done", busy, 1);
            end else begin
                chk("stream_gap", 1, 0);
            end
        end
        if (!got_done) chk("frame_done_timeout", 0, 1);
        @(negedge clk);
        chk("frame_done_pulse", frame_done, 0);
        chk("busy_after_done", busy, 0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_pixel_out"}, pixel_out, 0);
        chk({tag, "_pix_en"}, pix_en, 0);
        chk({tag, "_row_start"}, row_start, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    vec_t vecs[4];

    initial begin
        int  cyc;
        bit  seen;
        vecs[0] = '{hold_at: 0,  hold_len: 0, exp_cycles: NB + 2, wr_on_start: 1, busy_poke: 0};
        vecs[1] = '{hold_at: 10, hold_len: 3, exp_cycles: NB + 5, wr_on_start: 0, busy_poke: 0};
        vecs[2] = '{hold_at: 6,  hold_len: 2, exp_cycles: NB + 4, wr_on_start: 0, busy_poke: 1};
        vecs[3] = '{hold_at: 25, hold_len: 1, exp_cycles: NB + 3, wr_on_start: 0, busy_poke: 0};

        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; hold = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // addr 0 is written together with the first start
        for (int i = 1; i < IMG_N * IMG_N; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DATA_W'(i + 1);
        end
        @(negedge clk);
        wr_en = 1'b0;

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Abort mid-frame after value 20
        push_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge clk);
            if (pix_en) begin
                check_beat();
                if (pixel_out == 16'd20) seen = 1;
            end
        end
        if (!seen) chk("reach_value_20", 0, 1);
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("async_abort");
        start = 1'b1;
        @(negedge clk);
        chk("start_in_reset_busy", busy, 0);
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (frame_done || busy || pix_en) chk("post_abort_quiet", 1, 0);
        end
        chk("post_abort_busy", busy, 0);
        exp_q.delete();

        run_frame(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_feeder.md
Name: conv_feeder

Overview:
Frame-buffer streamer for the convolution datapath. Holds one IMG_N x IMG_N frame loaded over a simple write port. On start, replays the frame in row-major order as a one-pixel-per-cycle stream with a qualifying enable, which drives conv's pixel_in/en. Optional row padding clears the downstream K-tap window between rows.

Parameters:
DATA_W, 16, pixel width; must match conv DATA_W.
IMG_N, 6, frame is IMG_N x IMG_N pixels.
K, 3, downstream window length; sets pad count K-1.
AW, $clog2(IMG_N*IMG_N), derived local address width (localparam, not overridable).

Ports:
clk  in  1  clock; all logic posedge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
wr_en  in  1  frame-buffer write strobe.
wr_addr  in  AW  row-major write address (row*IMG_N+col).
wr_data  in  DATA_W  pixel to write.
start  in  1  one-cycle request to stream the frame.
hold  in  1  downstream stall; freezes the stream while 1.
pixel_out  out  DATA_W  streamed pixel (registered).
pix_en  out  1  pixel_out valid this cycle; connects to conv en.
row_start  out  1  high with the first pixel of each row.
frame_done  out  1  one-cycle pulse after the last stream beat.
busy  out  1  high from start accept until frame_done.

Behaviour:
- Reset (rst=0, async): FSM->IDLE; pixel_out=0, pix_en=0, row_start=0, frame_done=0, busy=0; row/col counters=0. Memory contents are not cleared.
- Memory: IMG_N*IMG_N x DATA_W, written synchronously on wr_en. Writes are accepted only in IDLE; wr_en while busy=1 is dropped. wr_addr >= IMG_N*IMG_N is ignored.
- FSM states: IDLE, STREAM, PAD, DONE.
- IDLE: start=1 -> STREAM, busy=1 on the next edge. start with simultaneous wr_en: the write lands first, then the stream begins. start while busy is ignored.
- STREAM: each cycle with hold=0 registers mem[row*IMG_N+col] onto pixel_out, sets pix_en=1, and advances col. row_start=1 when col==0.
  - col==IMG_N-1: col wraps to 0, then -> PAD (feature on) or next row (feature off).
  - Last pixel of last row -> DONE (feature off) or PAD (feature on).
- PAD: emits K-1 beats with pixel_out=0 and pix_en=1. Afterwards row++ and -> STREAM; after the last row -> DONE.
- DONE: pix_en=0, frame_done=1 for exactly one cycle, busy=0 on the following edge, -> IDLE.
- hold=1 in STREAM/PAD: pix_en=0, counters frozen, pixel_out holds its last value. Stream resumes on the same pixel when hold drops. hold is ignored in IDLE/DONE.
- Latency: start sampled at edge t -> first pix_en=1 at edge t+1, carrying mem[0].
- Beat count (hold=0): IMG_N*IMG_N without pad; IMG_N*(IMG_N+K-1) with pad. frame_done one cycle after the last beat.
- rst asserted mid-frame aborts immediately to the reset values above; no frame_done is issued.

Optional Feature:
Macro CONV_FEEDER_ROW_PAD_EN.
- Defined: PAD state present; K-1 zero beats follow every row, including the last, so conv's window never spans two rows.
- Undefined: PAD state and its counter are omitted; rows stream back-to-back.

Test Plan:
- Reset/idle: rst=0 mid-sim, async -> all outputs 0 within the same cycle; busy=0; start ignored while rst=0.
- Load mem[i]=i+1 (1..36), pulse start, hold=0, feature off -> 36 beats of 1..36 on consecutive cycles. row_start on values 1,7,13,19,25,31. frame_done one cycle after value 36.
- Same load, feature on (IMG_N=6, K=3) -> 48 beats: 1..6,0,0,7..12,0,0,...,31..36,0,0. row_start only on non-pad first pixels.
- hold=1 for 3 cycles after value 10 -> pix_en=0 for those 3 cycles, pixel_out stays 10, next beat is 11; total beat count unchanged.
- wr_en (addr 0, data 0xFFFF) and a second start, both during busy -> both dropped; a subsequent frame still outputs 1 first.
- rst pulse after value 20 -> stream stops, no frame_done. A fresh start restarts at value 1 with memory intact.
